spi_apb_master: RTL
===================

SPI_APB_MASTER -- requirements
Module: spi_apb_master

Parameters
REQ-001 The block SHALL take parameter ADDR_WIDE, default 32, as the APB address width.
REQ-002 The block SHALL take parameter DATA_WIDE, default 32, as the APB and command data width.
REQ-003 The block SHALL take parameter TIMEOUT_CYC, default 16, as the maximum ACCESS-phase cycles before abort; value 0 disables the timeout.

Interface
REQ-004 pclk_i  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 prst_i  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid_i  in  1  command request.
REQ-007 cmd_ready_o  out  1  command accept; a command SHALL transfer when cmd_valid_i and cmd_ready_o are both 1 at a clock edge.
REQ-008 cmd_write_i  in  1  1 = write, 0 = read.
REQ-009 cmd_addr_i  in  ADDR_WIDE  target address.
REQ-010 cmd_wdata_i  in  DATA_WIDE  write data.
REQ-011 rsp_valid_o  out  1  response available.
REQ-012 rsp_ready_i  in  1  response consumed.
REQ-013 rsp_rdata_o  out  DATA_WIDE  read data; 0 for writes and on timeout.
REQ-014 rsp_err_o  out  1  1 = transfer aborted by timeout.
REQ-015 paddr_o, pwrite_o, psel_o, penable_o, pwdata_o  out  ADDR_WIDE/1/1/1/DATA_WIDE  APB requester signals.
REQ-016 prdata_i  in  DATA_WIDE and pready_i  in  1  APB completer returns.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, ACCESS, and RESP.
REQ-018 cmd_ready_o SHALL be 1 only in IDLE.
REQ-019 On a command handshake in IDLE, the block SHALL register addr, write, and wdata onto paddr_o/pwrite_o/pwdata_o and go to SETUP on the next cycle.
REQ-020 In SETUP, psel_o SHALL be 1 and penable_o SHALL be 0 for exactly one cycle, then the FSM SHALL go to ACCESS.
REQ-021 In ACCESS, psel_o and penable_o SHALL both be 1; paddr_o, pwrite_o, and pwdata_o SHALL be stable from SETUP until exit from ACCESS.
REQ-022 In ACCESS, when pready_i is 1, the block SHALL capture prdata_i (for reads) into rsp_rdata_o, set rsp_err_o=0, deassert psel_o/penable_o on the next cycle, and go to RESP.
REQ-023 In ACCESS with TIMEOUT_CYC>0, a counter SHALL count ACCESS cycles with pready_i=0; when TIMEOUT_CYC such cycles have elapsed, the block SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0, and drop psel_o/penable_o.
REQ-024 pready_i=1 in the same cycle the timeout count is reached SHALL be treated as a normal completion (rsp_err_o=0).
REQ-025 The timeout counter SHALL clear on every entry to ACCESS and SHALL be wide enough to hold TIMEOUT_CYC without wrap.
REQ-026 In RESP, rsp_valid_o SHALL be 1, and rsp_rdata_o/rsp_err_o SHALL be held stable until rsp_ready_i=1; the FSM SHALL then return to IDLE on the next cycle.
REQ-027 Minimum latency from command handshake to rsp_valid_o SHALL be 3 cycles (SETUP, ACCESS with pready_i=1, RESP).
REQ-028 Write responses SHALL report rsp_rdata_o=0.
REQ-029 pready_i and prdata_i SHALL be ignored outside ACCESS.

Reset
REQ-030 While prst_i=1, the FSM SHALL be in IDLE and all outputs SHALL be 0, except cmd_ready_o, which SHALL be 1 after the reset edge.
REQ-031 Reset asserted mid-transfer SHALL immediately drop psel_o/penable_o and discard the pending response; no response SHALL be issued after release.

Verification
REQ-032 Read with zero wait: cmd read addr 0x10, pready_i=1 in first ACCESS cycle, prdata_i=0xA5A5_0001, rsp_ready_i=1 -> rsp_valid_o 3 cycles after handshake with rdata 0xA5A5_0001, err 0.
REQ-033 Write with 2 wait states: write addr 0x04, data 0xDEAD_BEEF -> psel_o high for 4 cycles, penable_o for 3, paddr/pwdata stable throughout, rsp rdata 0, err 0.
REQ-034 Timeout: TIMEOUT_CYC=16, pready_i held 0 -> exactly 16 ACCESS cycles, then psel_o=0, rsp_err_o=1, rsp_rdata_o=0.
REQ-035 Response back-pressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data held, cmd_ready_o=0, and a second cmd_valid_i is not accepted until the cycle after rsp_ready_i=1.
REQ-036 Reset in ACCESS: prst_i pulsed during ACCESS -> psel_o/penable_o=0 asynchronously, no rsp_valid_o after release, and the next command runs normally.
REQ-037 Boundary: pready_i=1 on the 16th ACCESS cycle with TIMEOUT_CYC=16 -> normal completion with err 0.

Source files
------------

// File: rtl/spi_apb_master.sv
// Command/response to APB requester bridge with an optional ACCESS-phase timeout.
// One transfer in flight; the response is held until the consumer takes it.
module spi_apb_master #(
    parameter int ADDR_WIDE   = 32,
    parameter int DATA_WIDE   = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 pclk_i,
    input  logic                 prst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [ADDR_WIDE-1:0] cmd_addr_i,
    input  logic [DATA_WIDE-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_WIDE-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [ADDR_WIDE-1:0] paddr_o,
    output logic                 pwrite_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic [DATA_WIDE-1:0] pwdata_o,
    input  logic [DATA_WIDE-1:0] prdata_i,
    input  logic                 pready_i
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t               r_state;
    logic                 r_cmd_ready;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [ADDR_WIDE-1:0] r_paddr;
    logic [DATA_WIDE-1:0] r_pwdata;
    logic                 r_rsp_valid;
    logic [DATA_WIDE-1:0] r_rsp_rdata;
    logic                 r_rsp_err;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_timeout;

    // r_cnt holds the number of wait cycles already spent, so the current
    // cycle is the last allowed one when it equals TIMEOUT_CYC-1.
    assign w_timeout = (TIMEOUT_CYC > 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_paddr     <= cmd_addr_i;
                        r_pwrite    <= cmd_write_i;
                        r_pwdata    <= cmd_wdata_i;
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (TIMEOUT_CYC > 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule
